arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of every channel in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 The block SHALL have parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-low reset; sampled on rising CLK edge.
REQ-006 IN_DATA  input  CHANNELS*WIDTH  flattened channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 IN_VALID  input  CHANNELS  per-channel valid.
REQ-008 IN_READY  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-009 SELECT_EN  input  1  1 = manual selection overrides arbitration.
REQ-010 SELECT  input  clog2(CHANNELS)  manual channel index, used only when SELECT_EN = 1.
REQ-011 OUT_DATA  output  WIDTH  registered selected data.
REQ-012 OUT_CHANNEL  output  clog2(CHANNELS)  index of the channel that supplied OUT_DATA.
REQ-013 OUT_VALID  output  1  OUT_DATA/OUT_CHANNEL hold a beat.
REQ-014 OUT_READY  input  1  downstream accepts the beat.

Function
REQ-015 A transfer SHALL occur on a channel when IN_VALID[k] and IN_READY[k] are both 1 at a rising edge; output transfer when OUT_VALID and OUT_READY are both 1.
REQ-016 The output register SHALL be loadable ("load") when OUT_VALID = 0 or OUT_READY = 1.
REQ-017 IN_READY SHALL be the one-hot grant gated by load; IN_READY SHALL be all-zero when load = 0 or no eligible channel is valid.
REQ-018 Grant SHALL be combinational from IN_VALID, SELECT_EN, SELECT and the priority pointer; IN_READY SHALL NOT depend on IN_DATA.
REQ-019 Latency SHALL be exactly one cycle: data accepted at edge N appears on OUT_DATA with OUT_VALID = 1 after edge N.
REQ-020 While OUT_VALID = 1 and OUT_READY = 0, OUT_DATA, OUT_CHANNEL and OUT_VALID SHALL stay stable.
REQ-021 On load with no grant, OUT_VALID SHALL clear to 0; OUT_DATA and OUT_CHANNEL SHALL hold their previous values.
REQ-022 Simultaneous output drain and input accept in one cycle SHALL replace the beat with no bubble (full throughput, one beat per cycle).
REQ-023 MODE 0: grant SHALL go to the first valid channel searching upward from pointer, wrapping from CHANNELS-1 to 0.
REQ-024 MODE 0: on each accepted input beat the pointer SHALL become (granted index + 1) mod CHANNELS; otherwise it SHALL hold.
REQ-025 MODE 1: grant SHALL go to the lowest-index valid channel; pointer SHALL be held at 0.
REQ-026 SELECT_EN = 1: only channel SELECT SHALL be eligible, in either MODE; pointer SHALL not change.
REQ-027 SELECT_EN = 1 with SELECT >= CHANNELS SHALL grant no channel.
REQ-028 SELECT_EN/SELECT changes while a beat is held SHALL not alter the held beat.

Reset
REQ-029 With RESET = 0 at a rising edge: OUT_VALID = 0, OUT_DATA = 0, OUT_CHANNEL = 0, pointer = 0.
REQ-030 While RESET = 0, IN_READY SHALL be all-zero.
REQ-031 Reset mid-operation SHALL discard any held output beat; no input beat SHALL be accepted in that cycle.

Structure
REQ-032 MODE encodings (MODE_RR = 0, MODE_FIXED = 1) SHALL live in a shared package used by datapath blocks.
REQ-033 Arbitration SHALL be a separate sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out); arb_mux holds the output register and pointer.

Verification
REQ-034 Reset: RESET = 0 for 2 cycles with all IN_VALID = 1 -> IN_READY = 0000, OUT_VALID = 0, OUT_DATA = 0x00.
REQ-035 RR fairness: CHANNELS = 4, all valid, data k = 0x10+k, OUT_READY = 1 -> OUT_CHANNEL sequence 0,1,2,3,0 with OUT_DATA 0x10,0x11,0x12,0x13,0x10.
REQ-036 Backpressure: beat 0xA5 from channel 2, OUT_READY = 0 for 3 cycles -> OUT_DATA = 0xA5 stable, IN_READY = 0000; OUT_READY = 1 -> next beat loads the same cycle.
REQ-037 Manual: SELECT_EN = 1, SELECT = 3, channels 0 and 3 valid (0x01, 0x33) -> only IN_READY[3] = 1, OUT_DATA = 0x33; SELECT = 5 (CHANNELS = 4) -> no grant, OUT_VALID drops to 0.
REQ-038 Fixed priority: MODE = 1, channels 1 and 2 valid -> channel 1 granted every cycle while valid.
REQ-039 Reset mid-stream: RESET = 0 while OUT_VALID = 1 holding 0x7E -> after edge OUT_VALID = 0, OUT_DATA = 0x00; after release the RR pointer restarts at channel 0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated channel mux.
// Policy encodings and index-width helper.
package arb_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  function automatic int idx_w(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first request at or above ptr wins.
// Fixed priority is the same search with ptr tied to zero.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int IW       = idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [IW-1:0]       idx
);

  always_comb begin : search
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int o = 0; o < CHANNELS; o++) begin
      k = (int'(ptr) + o) % CHANNELS;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated mux with a single registered output beat.
// Holds the output register and the rotating priority pointer.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_RR,
  localparam int IW       = idx_w(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  output logic [CHANNELS-1:0]       IN_READY,
  input  logic                      SELECT_EN,
  input  logic [IW-1:0]             SELECT,
  output logic [WIDTH-1:0]          OUT_DATA,
  output logic [IW-1:0]             OUT_CHANNEL,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY
);

  logic [IW-1:0]       ptr;
  logic [IW-1:0]       arb_ptr;
  logic [IW-1:0]       idx;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] gnt;
  logic                load;
  logic                sel_ok;
  logic                take;

  assign load   = !OUT_VALID || OUT_READY;
  assign sel_ok = int'(SELECT) < CHANNELS;

  always_comb begin
    req = IN_VALID;
    if (SELECT_EN) begin
      req = sel_ok
          ? (IN_VALID & (CHANNELS'(1) << SELECT))
          : '0;
    end
  end

  assign arb_ptr = (MODE == MODE_FIXED) ? '0 : ptr;

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .req(req),
    .ptr(arb_ptr),
    .gnt(gnt),
    .idx(idx)
  );

  // Grant is only exposed when the output slot can take it.
  assign IN_READY = (RESET && load) ? gnt : '0;
  assign take     = |IN_READY;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      OUT_VALID   <= 1'b0;
      OUT_DATA    <= '0;
      OUT_CHANNEL <= '0;
      ptr         <= '0;
    end else begin
      if (load) OUT_VALID <= take;
      if (take) begin
        OUT_DATA    <= IN_DATA[int'(idx)*WIDTH +: WIDTH];
        OUT_CHANNEL <= idx;
        if (MODE == MODE_RR && !SELECT_EN) begin
          ptr <= (idx == IW'(CHANNELS-1))
               ? '0 : idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench: RR and fixed-priority muxes vs a beat model,
// plus a 5-channel instance for out-of-range manual selects.
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        sel_en;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  rdy_r, rdy_f;
  logic [7:0]  od_r, od_f;
  logic [1:0]  oc_r, oc_f;
  logic        ov_r, ov_f;

  logic [2:0]  sel5;
  logic [4:0]  rdy5;
  logic [7:0]  od5;
  logic [2:0]  oc5;
  logic        ov5;

  int checks   = 0;
  int failures = 0;
  bit live     = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) dut_rr (
    .CLK(clk), .RESET(reset),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy_r),
    .SELECT_EN(sel_en), .SELECT(sel),
    .OUT_DATA(od_r), .OUT_CHANNEL(oc_r), .OUT_VALID(ov_r),
    .OUT_READY(out_ready)
  );

  arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) dut_fx (
    .CLK(clk), .RESET(reset),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy_f),
    .SELECT_EN(sel_en), .SELECT(sel),
    .OUT_DATA(od_f), .OUT_CHANNEL(oc_f), .OUT_VALID(ov_f),
    .OUT_READY(out_ready)
  );

  arb_mux #(.WIDTH(8), .CHANNELS(5), .MODE(0)) dut5 (
    .CLK(clk), .RESET(reset),
    .IN_DATA({8'h44, in_data}), .IN_VALID(5'b11111),
    .IN_READY(rdy5),
    .SELECT_EN(sel_en), .SELECT(sel5),
    .OUT_DATA(od5), .OUT_CHANNEL(oc5), .OUT_VALID(ov5),
    .OUT_READY(1'b1)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  // Beat model: index 0 = round-robin, 1 = fixed priority.
  int m_v[2], m_d[2], m_c[2], m_p[2];

  function automatic int pick(int p);
    if (sel_en) begin
      if (int'(sel) < 4 && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int o = 0; o < 4; o++)
      if (in_valid[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  function automatic int exp_rdy(int m);
    int g;
    if (!reset) return 0;
    if (m_v[m] != 0 && !out_ready) return 0;
    g = pick(m_p[m]);
    return (g < 0) ? 0 : (1 << g);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int g;
      if (!reset) begin
        m_v[m] = 0; m_d[m] = 0; m_c[m] = 0; m_p[m] = 0;
      end else if (m_v[m] == 0 || out_ready) begin
        g = pick(m_p[m]);
        m_v[m] = (g >= 0) ? 1 : 0;
        if (g >= 0) begin
          m_d[m] = int'(in_data[g*8 +: 8]);
          m_c[m] = g;
          if (m == 0 && !sel_en) m_p[m] = (g + 1) % 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("rr_ready", 32'(rdy_r), 32'(exp_rdy(0)));
      chk("rr_valid", 32'(ov_r),  32'(m_v[0]));
      chk("rr_data",  32'(od_r),  32'(m_d[0]));
      chk("rr_chan",  32'(oc_r),  32'(m_c[0]));
      chk("fx_ready", 32'(rdy_f), 32'(exp_rdy(1)));
      chk("fx_valid", 32'(ov_f),  32'(m_v[1]));
      chk("fx_data",  32'(od_f),  32'(m_d[1]));
      chk("fx_chan",  32'(oc_f),  32'(m_c[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] rr_seq [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  initial begin
    reset     = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'h13121110;
    sel_en    = 1'b0;
    sel       = 2'd0;
    sel5      = 3'd0;
    out_ready = 1'b1;
    tick();
    live = 1;
    tick();
    chk("rst_ready", 32'(rdy_r), 32'h0);
    chk("rst_valid", 32'(ov_r),  32'h0);
    chk("rst_data",  32'(od_r),  32'h00);

    reset = 1'b1;
    #1;
    chk("rr_first_ready", 32'(rdy_r), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq_data", 32'(od_r), 32'(rr_seq[i]));
      chk("rr_seq_chan", 32'(oc_r), 32'(i % 4));
    end

    in_valid = 4'b0100;
    in_data  = 32'h13A51110;
    tick();
    chk("bp_load", 32'(od_r), 32'hA5);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      sel_en = i[0];
      sel    = 2'(i);
      tick();
      chk("bp_hold_data",  32'(od_r),  32'hA5);
      chk("bp_hold_ready", 32'(rdy_r), 32'h0);
    end
    sel_en    = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rdy_r), 32'b1000);
    tick();
    chk("bp_next_chan", 32'(oc_r), 32'd3);
    chk("bp_next_data", 32'(od_r), 32'h13);

    sel_en   = 1'b1;
    sel      = 2'd3;
    sel5     = 3'd4;
    in_valid = 4'b1001;
    in_data  = 32'h33000001;
    #1;
    chk("man_ready", 32'(rdy_r), 32'b1000);
    chk("man5_ready4", 32'(rdy5), 32'b10000);
    tick();
    chk("man_data", 32'(od_r), 32'h33);
    sel  = 2'd1;
    sel5 = 3'd5;
    #1;
    chk("man5_ready5", 32'(rdy5), 32'h0);
    tick();
    chk("man_drop_valid", 32'(ov_r), 32'h0);
    chk("man_keep_data", 32'(od_r), 32'h33);
    sel5 = 3'd7;
    #1;
    chk("man5_ready7", 32'(rdy5), 32'h0);

    sel_en   = 1'b0;
    in_valid = 4'b0110;
    in_data  = 32'h00222100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fx_pri_ready", 32'(rdy_f), 32'b0010);
      tick();
      chk("fx_pri_chan", 32'(oc_f), 32'd1);
    end

    in_valid = 4'b0001;
    in_data  = 32'h0000007E;
    tick();
    chk("mid_data", 32'(od_r), 32'h7E);
    out_ready = 1'b0;
    reset     = 1'b0;
    in_valid  = 4'hF;
    #1;
    chk("mid_rst_ready", 32'(rdy_r), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(ov_r), 32'h0);
    chk("mid_rst_data",  32'(od_r), 32'h00);
    reset     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h13121110;
    #1;
    chk("mid_ptr_ready", 32'(rdy_r), 32'b0001);
    tick();
    chk("mid_ptr_chan", 32'(oc_r), 32'd0);
    tick();
    chk("mid_ptr_next", 32'(oc_r), 32'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
